// File: rtl/branch_comparer_serial.sv
// Multi-cycle RV32I branch comparator: scans RS1/RS2 one digit per cycle, MSB digit first,
// and reports eq / less-signed / less-unsigned flags plus the branch-taken decision.
module branch_comparer_serial #(
    parameter int DATA_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 8,
    parameter bit EARLY_EXIT  = 1'b1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_dataRS1,
    input  logic [DATA_WIDTH-1:0] i_dataRS2,
    input  logic [2:0]            i_funct3,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_isEqual,
    output logic                  o_isLessSigned,
    output logic                  o_isLessUnsigned,
    output logic                  o_taken,
    output logic                  o_illegal
);

    localparam int unsigned NDIG = DATA_WIDTH / ((DIGIT_WIDTH >= 1) ? DIGIT_WIDTH : 1);
    localparam int unsigned KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Reject parameter sets that cannot be split into whole digits
    if (DIGIT_WIDTH < 1) begin : g_bad_digit
        $fatal(1, "branch_comparer_serial: DIGIT_WIDTH must be >= 1");
    end else if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_ratio
        $fatal(1, "branch_comparer_serial: DATA_WIDTH must be a multiple of DIGIT_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   rs1_q;
    logic [DATA_WIDTH-1:0]   rs2_q;
    logic [2:0]              funct3_q;
    logic [KW-1:0]           k_q;
    logic                    diff_found_q;
    logic                    ltu_first_q;
    logic                    ready_q;
    logic                    valid_q;
    logic                    eq_q;
    logic                    lts_q;
    logic                    ltu_q;
    logic                    taken_q;
    logic                    illegal_q;

    logic [DIGIT_WIDTH-1:0]  a_dig;
    logic [DIGIT_WIDTH-1:0]  b_dig;
    logic                    dig_diff;
    logic                    finish;
    logic                    neq;
    logic                    ltu_res;
    logic                    lts_res;
    logic                    taken_res;
    logic                    illegal_res;

    // Current digit compare and the final flag/decision values used when the scan ends
    always_comb begin
        a_dig       = DIGIT_WIDTH'(rs1_q >> (32'(k_q) * DIGIT_WIDTH));
        b_dig       = DIGIT_WIDTH'(rs2_q >> (32'(k_q) * DIGIT_WIDTH));
        dig_diff    = (a_dig != b_dig);
        finish      = (k_q == '0) || (EARLY_EXIT && dig_diff);
        neq         = diff_found_q || dig_diff;
        ltu_res     = diff_found_q ? ltu_first_q : (a_dig < b_dig);
        lts_res     = 1'b0;
        if (neq) begin
            lts_res = (rs1_q[DATA_WIDTH-1] ^ rs2_q[DATA_WIDTH-1]) ? rs1_q[DATA_WIDTH-1] : ltu_res;
        end
        taken_res   = 1'b0;
        illegal_res = 1'b0;
        case (funct3_q)
            3'b000:  taken_res = !neq;
            3'b001:  taken_res = neq;
            3'b100:  taken_res = lts_res;
            3'b101:  taken_res = !lts_res;
            3'b110:  taken_res = ltu_res;
            3'b111:  taken_res = !ltu_res;
            default: illegal_res = 1'b1;
        endcase
    end

    // Control FSM with registered handshake and result outputs; flush overrides everything
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= S_IDLE;
            rs1_q        <= '0;
            rs2_q        <= '0;
            funct3_q     <= '0;
            k_q          <= '0;
            diff_found_q <= 1'b0;
            ltu_first_q  <= 1'b0;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            eq_q         <= 1'b0;
            lts_q        <= 1'b0;
            ltu_q        <= 1'b0;
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (i_flush) begin
            state_q      <= S_IDLE;
            diff_found_q <= 1'b0;
            ltu_first_q  <= 1'b0;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            eq_q         <= 1'b0;
            lts_q        <= 1'b0;
            ltu_q        <= 1'b0;
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid && ready_q) begin
                        rs1_q        <= i_dataRS1;
                        rs2_q        <= i_dataRS2;
                        funct3_q     <= i_funct3;
                        k_q          <= KW'(NDIG - 1);
                        diff_found_q <= 1'b0;
                        ltu_first_q  <= 1'b0;
                        ready_q      <= 1'b0;
                        state_q      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (finish) begin
                        valid_q   <= 1'b1;
                        eq_q      <= !neq;
                        lts_q     <= lts_res;
                        ltu_q     <= neq && ltu_res;
                        taken_q   <= taken_res;
                        illegal_q <= illegal_res;
                        state_q   <= S_DONE;
                    end else begin
                        k_q <= k_q - KW'(1);
                        if (dig_diff && !diff_found_q) begin
                            diff_found_q <= 1'b1;
                            ltu_first_q  <= (a_dig < b_dig);
                        end
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        valid_q   <= 1'b0;
                        eq_q      <= 1'b0;
                        lts_q     <= 1'b0;
                        ltu_q     <= 1'b0;
                        taken_q   <= 1'b0;
                        illegal_q <= 1'b0;
                        ready_q   <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready          = ready_q;
    assign o_valid          = valid_q;
    assign o_isEqual        = eq_q;
    assign o_isLessSigned   = lts_q;
    assign o_isLessUnsigned = ltu_q;
    assign o_taken          = taken_q;
    assign o_illegal        = illegal_q;

endmodule

// File: tb/tb_branch_comparer_serial.sv
// Directed bench for branch_comparer_serial: latency, flags, hold, flush and async reset.
module tb_branch_comparer_serial;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic        rdy, vld, eq, lts, ltu, tkn, ill;
    logic        in_valid2, out_ready2;
    logic        rdy2, vld2, eq2, lts2, ltu2, tkn2, ill2;

    int errors = 0;
    int checks = 0;

    branch_comparer_serial #(.DATA_WIDTH(32), .DIGIT_WIDTH(8), .EARLY_EXIT(1'b1)) u_dut (
        .i_clock(clk), .i_reset(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(rdy),
        .i_dataRS1(rs1), .i_dataRS2(rs2), .i_funct3(f3), .o_valid(vld), .i_ready(out_ready),
        .o_isEqual(eq), .o_isLessSigned(lts), .o_isLessUnsigned(ltu), .o_taken(tkn), .o_illegal(ill)
    );

    branch_comparer_serial #(.DATA_WIDTH(32), .DIGIT_WIDTH(8), .EARLY_EXIT(1'b0)) u_dut_full (
        .i_clock(clk), .i_reset(rst_n), .i_flush(flush), .i_valid(in_valid2), .o_ready(rdy2),
        .i_dataRS1(rs1), .i_dataRS2(rs2), .i_funct3(f3), .o_valid(vld2), .i_ready(out_ready2),
        .o_isEqual(eq2), .o_isLessSigned(lts2), .o_isLessUnsigned(ltu2), .o_taken(tkn2), .o_illegal(ill2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic e_eq, input logic e_lts,
                             input logic e_ltu, input logic e_tkn, input logic e_ill);
        chk({tag, "_valid"}, vld, 1'b1);
        chk({tag, "_ready"}, rdy, 1'b0);
        chk({tag, "_eq"}, eq, e_eq);
        chk({tag, "_lts"}, lts, e_lts);
        chk({tag, "_ltu"}, ltu, e_ltu);
        chk({tag, "_taken"}, tkn, e_tkn);
        chk({tag, "_illegal"}, ill, e_ill);
    endtask

    // Present one request, scramble the operands after acceptance, and measure cycles to o_valid
    task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input int exp_m);
        int cnt;
        @(negedge clk);
        in_valid = 1'b1;
        rs1 = a;
        rs2 = b;
        f3  = f;
        @(negedge clk);
        in_valid = 1'b0;
        rs1 = ~a;
        rs2 = a;
        f3  = ~f;
        cnt = 0;
        while (vld !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk_int({tag, "_latency"}, cnt, exp_m);
    endtask

    // Consume the result and confirm the block returns to IDLE
    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_cons_valid"}, vld, 1'b0);
        chk({tag, "_cons_ready"}, rdy, 1'b1);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0;
        rs1 = '0; rs2 = '0; f3 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", rdy, 1'b1);
        chk("rst_valid", vld, 1'b0);
        chk("rst_eq", eq, 1'b0);
        chk("rst_taken", tkn, 1'b0);
        rst_n = 1'b1;

        // Equal operands, BEQ: full 4-digit scan
        do_req("t1", 32'h12345678, 32'h12345678, 3'b000, 4);
        chk_flags("t1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        consume("t1");

        // -1 < 1 signed, BLT: MSB digit differs, early exit after one digit
        do_req("t2", 32'hFFFFFFFF, 32'h00000001, 3'b100, 1);
        chk_flags("t2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        consume("t2");

        // Same operands on the full-scan instance
        @(negedge clk);
        in_valid2 = 1'b1; rs1 = 32'hFFFFFFFF; rs2 = 32'h00000001; f3 = 3'b100;
        @(negedge clk);
        in_valid2 = 1'b0; rs1 = 32'h0; rs2 = 32'h0; f3 = 3'b000;
        cnt = 0;
        while (vld2 !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk_int("t2b_latency", cnt, 4);
        chk("t2b_eq", eq2, 1'b0);
        chk("t2b_lts", lts2, 1'b1);
        chk("t2b_ltu", ltu2, 1'b0);
        chk("t2b_taken", tkn2, 1'b1);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        chk("t2b_cons_ready", rdy2, 1'b1);

        // BGEU 0x100 vs 0xFF: third digit differs
        do_req("t3", 32'h00000100, 32'h000000FF, 3'b111, 3);
        chk_flags("t3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        consume("t3");

        // MSBs equal, difference in last digit: signed follows unsigned
        do_req("t3b", 32'hFFFFFFFE, 32'hFFFFFFFF, 3'b100, 4);
        chk_flags("t3b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        consume("t3b");

        // Hold result with i_ready low while a new request is pulsed
        do_req("t4", 32'h80000000, 32'h7FFFFFFF, 3'b101, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            rs1 = 32'h1; rs2 = 32'h2; f3 = 3'b110;
            chk_flags("t4_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b1;
        consume("t4");
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4_no_accept", vld, 1'b0);
        chk("t4_idle_ready", rdy, 1'b1);

        // Flush in the second scan cycle
        @(negedge clk);
        in_valid = 1'b1; rs1 = 32'h12345678; rs2 = 32'h12345678; f3 = 3'b000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t5_flush_ready", rdy, 1'b1);
        repeat (6) @(negedge clk);
        chk("t5_flush_novalid", vld, 1'b0);

        // Request coincident with flush is dropped
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_flush_req_ready", rdy, 1'b1);
        repeat (6) @(negedge clk);
        chk("t5_flush_req_novalid", vld, 1'b0);

        // BLTU 5 < 7
        do_req("t5", 32'd5, 32'd7, 3'b110, 4);
        chk_flags("t5", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        consume("t5");

        // Flush while holding a result clears it
        do_req("t5c", 32'd1, 32'd2, 3'b000, 4);
        chk_flags("t5c", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t5c_flush_valid", vld, 1'b0);
        chk("t5c_flush_ltu", ltu, 1'b0);
        chk("t5c_flush_ready", rdy, 1'b1);

        // Async reset mid-scan
        @(negedge clk);
        in_valid = 1'b1; rs1 = 32'hA; rs2 = 32'hA; f3 = 3'b001;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", rdy, 1'b1);
        chk("t6_rst_valid", vld, 1'b0);
        chk("t6_rst_eq", eq, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal funct3 still completes the scan
        do_req("t6", 32'h0000000A, 32'h0000000A, 3'b010, 4);
        chk_flags("t6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        consume("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
